// File: rtl/if_fetch_if.sv
// Instruction-memory fetch bus: request/grant issue with in-order response return.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: owns the PC, issues word fetches, buffers returned
// instructions with their addresses and presents one per cycle to IF/ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  if_fetch_if.master  imem,
  output logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   aq [DEPTH];
  logic [AW-1:0] aq_rd;
  logic [AW-1:0] aq_wr;

  logic [31:0]   buf_addr [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW:0]   in_use;
  logic          grant;
  logic          rsp;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // Dropped responses stay in 'outstanding' until they return, so they keep holding credit.
  assign in_use        = {1'b0, outstanding} + {1'b0, count};
  assign imem.imem_req = rst && !flush && (in_use < LIMIT);
  assign imem.imem_addr = pc;

  assign grant    = imem.imem_req && imem.imem_gnt;
  assign rsp      = imem.imem_rvalid && (outstanding != '0);
  assign rsp_drop = rsp && (drop != '0);
  assign rsp_keep = rsp && (drop == '0);
  assign push     = rsp_keep && !flush;

  assign if_valid = (count != '0) && !flush;
  assign pop      = if_valid && !stall;
  // Bubbles go out as all-zero words, which IF/ID decodes as NOP.
  assign if_addr  = if_valid ? buf_addr[rd_ptr] : '0;
  assign if_data  = if_valid ? buf_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      aq_rd       <= '0;
      aq_wr       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      if (flush) begin
        pc     <= flush_pc;
        aq_rd  <= '0;
        aq_wr  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // Everything still in flight after this cycle's response belongs to the old stream.
        drop   <= outstanding - CW'(rsp);
      end else begin
        if (grant) begin
          pc    <= pc + 32'd4;
          aq_wr <= aq_wr + 1'b1;
        end
        if (rsp_drop) begin
          drop <= drop - 1'b1;
        end
        if (rsp_keep) begin
          aq_rd  <= aq_rd + 1'b1;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      aq[aq_wr] <= pc;
    end
    if (push) begin
      buf_addr[wr_ptr] <= aq[aq_rd];
      buf_data[wr_ptr] <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed phases push expected fetch addresses,
// a memory model answers in order, and a monitor checks every consumed instruction.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_valid;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .flush_pc (flush_pc),
    .imem     (bus),
    .if_addr  (if_addr),
    .if_data  (if_data),
    .if_valid (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mem_q [$];
  int    mem_lat  = 1;
  int    cyc      = 0;
  int    inflight = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // In-order memory: grants are sampled before the edge, responses appear mem_lat cycles later.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        assert (inflight > 0) else $error("response with nothing in flight");
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_q[0].addr ^ 32'hA5A5_0000;
        void'(mem_q.pop_front());
        inflight--;
      end
      #3;
      if (!rst) begin
        mem_q.delete();
        inflight = 0;
      end else if (bus.imem_req && bus.imem_gnt) begin
        mem_q.push_back('{bus.imem_addr, cyc + mem_lat});
        inflight++;
      end
    end
  end

  // Monitor: every consumed instruction must be the next expected one; bubbles must be zero.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got addr %h, expected none", if_addr);
        end else begin
          e = exp_q.pop_front();
          check("if_addr", if_addr, e);
          check("if_data", if_data, e ^ 32'hA5A5_0000);
        end
      end else if (!if_valid) begin
        check("bubble_addr", if_addr, 32'h0);
        check("bubble_data", if_data, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    bus.imem_gnt = 1'b0;
    mem_lat      = 1;

    @(negedge clk); #1;
    check("rst_req",    {31'b0, bus.imem_req}, 32'h0);
    check("rst_valid",  {31'b0, if_valid}, 32'h0);
    check("rst_addr",   if_addr, 32'h0);
    check("rst_data",   if_data, 32'h0);
    check("rst_pc",     bus.imem_addr, 32'h0);

    // Streaming from reset, then a 6-cycle stall while 0x10 is presented.
    @(negedge clk);
    for (int a = 0; a <= 'h60; a += 4) exp_q.push_back(32'(a));
    rst = 1'b1;
    bus.imem_gnt = 1'b1;
    @(negedge clk); #1;
    check("first_lat_c1", {31'b0, if_valid}, 32'h0);
    @(negedge clk); #1;
    check("first_lat_c2", {31'b0, if_valid}, 32'h1);
    repeat (4) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk); #1;
    check("stall_req_drop", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk); #1;
    check("stall_valid", {31'b0, if_valid}, 32'h1);
    check("stall_addr",  if_addr, 32'h10);
    check("stall_pc",    bus.imem_addr, 32'h20);
    repeat (2) @(negedge clk); #1;
    check("stall_hold",  if_addr, 32'h10);
    @(negedge clk);
    stall = 1'b0;
    repeat (18) @(negedge clk);
    bus.imem_gnt = 1'b0;
    repeat (6) @(negedge clk); #1;
    check("drain1_left", 32'(exp_q.size()), 32'h0);
    check("drain1_pc",   bus.imem_addr, 32'h64);
    check("drain1_idle", {31'b0, if_valid}, 32'h0);

    // Flush with two responses still out and one arriving in the flush cycle.
    @(negedge clk);
    mem_lat = 3;
    bus.imem_gnt = 1'b1;
    for (int a = 'h400; a <= 'h40C; a += 4) exp_q.push_back(32'(a));
    repeat (4) @(negedge clk);
    flush    = 1'b1;
    flush_pc = 32'h400;
    stall    = 1'b1;
    #1;
    check("flush_req",   {31'b0, bus.imem_req}, 32'h0);
    check("flush_valid", {31'b0, if_valid}, 32'h0);
    check("flush_addr",  if_addr, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check("redirect_pc", bus.imem_addr, 32'h400);
    repeat (4) @(negedge clk);
    bus.imem_gnt = 1'b0;
    repeat (10) @(negedge clk); #1;
    check("drain2_left", 32'(exp_q.size()), 32'h0);
    check("drain2_pc",   bus.imem_addr, 32'h410);

    // Redirect near the top of the address space: zero-wait latency and PC wrap.
    @(negedge clk);
    mem_lat      = 1;
    flush        = 1'b1;
    flush_pc     = 32'hFFFF_FFF0;
    bus.imem_gnt = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(32'hFFFF_FFF0 + 32'(4 * i));
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("wrap_pc0", bus.imem_addr, 32'hFFFF_FFF0);
    @(negedge clk); #1;
    check("redir_lat2", {31'b0, if_valid}, 32'h0);
    @(negedge clk); #1;
    check("redir_lat3", {31'b0, if_valid}, 32'h1);
    check("redir_addr", if_addr, 32'hFFFF_FFF0);
    @(negedge clk); #1;
    check("wrap_pc_top", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_pc_zero", bus.imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    bus.imem_gnt = 1'b0;
    repeat (6) @(negedge clk); #1;
    check("drain3_left", 32'(exp_q.size()), 32'h0);
    check("drain3_pc",   bus.imem_addr, 32'hC);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    bus.imem_gnt = 1'b1;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    bus.imem_gnt = 1'b0;
    #1;
    check("arst_valid", {31'b0, if_valid}, 32'h0);
    check("arst_addr",  if_addr, 32'h0);
    check("arst_data",  if_data, 32'h0);
    check("arst_req",   {31'b0, bus.imem_req}, 32'h0);
    repeat (2) @(negedge clk);

    // Restart at RESET_PC, then withhold grant for three cycles at 0x8.
    rst = 1'b1;
    bus.imem_gnt = 1'b1;
    for (int a = 0; a <= 'h10; a += 4) exp_q.push_back(32'(a));
    #1;
    check("restart_pc", bus.imem_addr, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      #1;
      check("nogrant_pc",  bus.imem_addr, 32'h8);
      check("nogrant_req", {31'b0, bus.imem_req}, 32'h1);
    end
    check("nogrant_valid", {31'b0, if_valid}, 32'h0);
    check("nogrant_data",  if_data, 32'h0);
    @(negedge clk);
    bus.imem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    bus.imem_gnt = 1'b0;
    repeat (6) @(negedge clk); #1;
    check("drain4_left", 32'(exp_q.size()), 32'h0);
    check("drain4_pc",   bus.imem_addr, 32'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
